// File: rtl/ahb_mtx_input_stage.sv
// Per-master input stage of the L1 AHB bus matrix: forwards or holds the master's
// address phase toward the output-stage arbiters and returns the slave's data-phase response.
module ahb_mtx_input_stage #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] HOLD_RESET_ADDR = '0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  output logic                  HREADYOUTS,
  output logic                  HRESPS,
  input  logic                  active_ip,
  input  logic                  HREADYM,
  input  logic                  readyout_ip,
  input  logic                  resp_ip,
  output logic                  req_op,
  output logic                  sel_op,
  output logic [ADDR_WIDTH-1:0] addr_op,
  output logic [1:0]            trans_op,
  output logic                  write_op,
  output logic [2:0]            size_op,
  output logic [2:0]            burst_op,
  output logic [3:0]            prot_op,
  output logic                  mastlock_op
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PEND = 2'b01,
    ST_DATA = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic                  hold_sel_q,   hold_sel_d;
  logic [ADDR_WIDTH-1:0] hold_addr_q,  hold_addr_d;
  logic [1:0]            hold_trans_q, hold_trans_d;
  logic                  hold_write_q, hold_write_d;
  logic [2:0]            hold_size_q,  hold_size_d;
  logic [2:0]            hold_burst_q, hold_burst_d;
  logic [3:0]            hold_prot_q,  hold_prot_d;
  logic                  hold_lock_q,  hold_lock_d;

  logic live_gate;
  logic new_tx;
  logic granted;
  logic capture;

  assign live_gate = HSELS & HREADYS;
  assign new_tx    = live_gate & HTRANSS[1];
  assign granted   = active_ip & HREADYM;

  // A data phase that is still waiting on the slave blocks new address phases;
  // once it completes, the same-cycle address phase is handled exactly as from IDLE.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (new_tx) begin
          if (granted) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_PEND;
            capture = 1'b1;
          end
        end
      end
      ST_PEND: begin
        if (granted) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (readyout_ip) begin
          if (new_tx && granted) begin
            state_d = ST_DATA;
          end else if (new_tx) begin
            state_d = ST_PEND;
            capture = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    hold_sel_d   = hold_sel_q;
    hold_addr_d  = hold_addr_q;
    hold_trans_d = hold_trans_q;
    hold_write_d = hold_write_q;
    hold_size_d  = hold_size_q;
    hold_burst_d = hold_burst_q;
    hold_prot_d  = hold_prot_q;
    hold_lock_d  = hold_lock_q;
    if (capture) begin
      hold_sel_d   = HSELS;
      hold_addr_d  = HADDRS;
      hold_trans_d = HTRANSS;
      hold_write_d = HWRITES;
      hold_size_d  = HSIZES;
      hold_burst_d = HBURSTS;
      hold_prot_d  = HPROTS;
      hold_lock_d  = HMASTLOCKS;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= ST_IDLE;
      hold_sel_q   <= 1'b0;
      hold_addr_q  <= HOLD_RESET_ADDR;
      hold_trans_q <= 2'b00;
      hold_write_q <= 1'b0;
      hold_size_q  <= 3'b000;
      hold_burst_q <= 3'b000;
      hold_prot_q  <= 4'b0000;
      hold_lock_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_sel_q   <= hold_sel_d;
      hold_addr_q  <= hold_addr_d;
      hold_trans_q <= hold_trans_d;
      hold_write_q <= hold_write_d;
      hold_size_q  <= hold_size_d;
      hold_burst_q <= hold_burst_d;
      hold_prot_q  <= hold_prot_d;
      hold_lock_q  <= hold_lock_d;
    end
  end

  // Master-facing response: ERROR's two-cycle sequence comes straight from the slave.
  always_comb begin
    HREADYOUTS = 1'b1;
    HRESPS     = 1'b0;
    unique case (state_q)
      ST_PEND: begin
        HREADYOUTS = 1'b0;
      end
      ST_DATA: begin
        HREADYOUTS = readyout_ip;
        HRESPS     = resp_ip;
      end
      default: begin
        HREADYOUTS = 1'b1;
        HRESPS     = 1'b0;
      end
    endcase
  end

  always_comb begin
    sel_op      = 1'b0;
    addr_op     = '0;
    trans_op    = 2'b00;
    write_op    = 1'b0;
    size_op     = 3'b000;
    burst_op    = 3'b000;
    prot_op     = 4'b0000;
    mastlock_op = 1'b0;
    if (state_q == ST_PEND) begin
      sel_op      = hold_sel_q;
      addr_op     = hold_addr_q;
      trans_op    = hold_trans_q;
      write_op    = hold_write_q;
      size_op     = hold_size_q;
      burst_op    = hold_burst_q;
      prot_op     = hold_prot_q;
      mastlock_op = hold_lock_q;
    end else if (live_gate) begin
      sel_op      = HSELS;
      addr_op     = HADDRS;
      trans_op    = HTRANSS;
      write_op    = HWRITES;
      size_op     = HSIZES;
      burst_op    = HBURSTS;
      prot_op     = HPROTS;
      mastlock_op = HMASTLOCKS;
    end
  end

  assign req_op = (state_q == ST_PEND) | new_tx;

endmodule

// File: tb/tb_ahb_mtx_input_stage.sv
// Self-checking bench for ahb_mtx_input_stage: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the port.
module tb_ahb_mtx_input_stage;

  localparam int          AW        = 32;
  localparam logic [31:0] RST_ADDR  = 32'hDEAD_0000;

  typedef struct packed {
    logic        sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        lock;
  } xfer_t;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          HSELS;
  logic [AW-1:0] HADDRS;
  logic [1:0]    HTRANSS;
  logic          HWRITES;
  logic [2:0]    HSIZES;
  logic [2:0]    HBURSTS;
  logic [3:0]    HPROTS;
  logic          HMASTLOCKS;
  logic          HREADYS;
  logic          HREADYOUTS;
  logic          HRESPS;
  logic          active_ip;
  logic          HREADYM;
  logic          readyout_ip;
  logic          resp_ip;
  logic          req_op;
  logic          sel_op;
  logic [AW-1:0] addr_op;
  logic [1:0]    trans_op;
  logic          write_op;
  logic [2:0]    size_op;
  logic [2:0]    burst_op;
  logic [3:0]    prot_op;
  logic          mastlock_op;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: at most one address phase waiting for a grant, and at most one data phase in flight.
  logic  m_pend;
  logic  m_data;
  xfer_t m_hold;

  always #5 HCLK = ~HCLK;

  ahb_mtx_input_stage #(
    .ADDR_WIDTH      (AW),
    .HOLD_RESET_ADDR (RST_ADDR)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HSELS       (HSELS),
    .HADDRS      (HADDRS),
    .HTRANSS     (HTRANSS),
    .HWRITES     (HWRITES),
    .HSIZES      (HSIZES),
    .HBURSTS     (HBURSTS),
    .HPROTS      (HPROTS),
    .HMASTLOCKS  (HMASTLOCKS),
    .HREADYS     (HREADYS),
    .HREADYOUTS  (HREADYOUTS),
    .HRESPS      (HRESPS),
    .active_ip   (active_ip),
    .HREADYM     (HREADYM),
    .readyout_ip (readyout_ip),
    .resp_ip     (resp_ip),
    .req_op      (req_op),
    .sel_op      (sel_op),
    .addr_op     (addr_op),
    .trans_op    (trans_op),
    .write_op    (write_op),
    .size_op     (size_op),
    .burst_op    (burst_op),
    .prot_op     (prot_op),
    .mastlock_op (mastlock_op)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic wr,
                               input logic [31:0] addr, input logic act, input logic hrm,
                               input logic rdy, input logic rsp);
    HSELS       = sel;
    HTRANSS     = trans;
    HWRITES     = wr;
    HADDRS      = addr;
    active_ip   = act;
    HREADYM     = hrm;
    readyout_ip = rdy;
    resp_ip     = rsp;
    HSIZES      = 3'($urandom_range(0, 7));
    HBURSTS     = 3'($urandom_range(0, 7));
    HPROTS      = 4'($urandom_range(0, 15));
    HMASTLOCKS  = 1'($urandom_range(0, 1));
  endtask

  // One bus cycle: the single master sees this port's own HREADYOUT as bus HREADY.
  task automatic runCycle(input bit check_en);
    logic  exp_ready, exp_resp, nt, grant;
    xfer_t live;
    exp_ready = m_pend ? 1'b0 : (m_data ? readyout_ip : 1'b1);
    exp_resp  = (!m_pend && m_data) ? resp_ip : 1'b0;
    HREADYS   = exp_ready;
    live      = '{HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS};
    nt        = HSELS && HREADYS && HTRANSS[1];
    grant     = active_ip && HREADYM;
    #2;
    if (check_en) begin
      checkOutput("hreadyouts", 64'(HREADYOUTS), 64'(exp_ready));
      checkOutput("hresps",     64'(HRESPS),     64'(exp_resp));
      checkOutput("req_op",     64'(req_op),     64'(m_pend || nt));
      if (m_pend) begin
        checkOutput("held_xfer",
                    64'({sel_op, addr_op, trans_op, write_op, size_op, burst_op, prot_op, mastlock_op}),
                    64'(m_hold));
      end else if (HSELS && HREADYS) begin
        checkOutput("live_xfer",
                    64'({sel_op, addr_op, trans_op, write_op, size_op, burst_op, prot_op, mastlock_op}),
                    64'(live));
      end else begin
        checkOutput("trans_op_gated", 64'(trans_op), 64'd0);
      end
    end
    @(posedge HCLK);
    if (HRESET) begin
      m_pend = 1'b0;
      m_data = 1'b0;
      m_hold = '{1'b0, RST_ADDR, 2'b00, 1'b0, 3'b000, 3'b000, 4'b0000, 1'b0};
    end else if (m_pend) begin
      if (grant) begin
        m_pend = 1'b0;
        m_data = 1'b1;
      end
    end else if (!m_data || readyout_ip) begin
      m_data = 1'b0;
      if (nt) begin
        if (grant) begin
          m_data = 1'b1;
        end else begin
          m_pend = 1'b1;
          m_hold = live;
        end
      end
    end
    @(negedge HCLK);
  endtask

  initial begin
    m_pend = 1'b0;
    m_data = 1'b0;
    m_hold = '0;
    HRESET = 1'b1;
    HREADYS = 1'b1;
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge HCLK);

    $display("[TB] reset");
    runCycle(1'b0);
    runCycle(1'b0);
    HRESET = 1'b0;
    runCycle(1'b1);
    checkOutput("reset_trans_op", 64'(trans_op), 64'd0);

    $display("[TB] pass-through write");
    applyStimulus(1'b1, 2'b10, 1'b1, 32'h2000_0010, 1'b1, 1'b1, 1'b1, 1'b0);
    runCycle(1'b1);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    runCycle(1'b1);

    $display("[TB] held read");
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h4000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
    runCycle(1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'b10, 1'b0, $urandom, (i == 2), 1'b1, 1'b1, 1'b0);
      #1;
      checkOutput("pend_addr", 64'(addr_op), 64'h4000_0000);
      #(-1 + 1);
      runCycle(1'b1);
    end
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    runCycle(1'b1);

    $display("[TB] error response");
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h5000_0040, 1'b1, 1'b1, 1'b1, 1'b0);
    runCycle(1'b1);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h5000_0040, 1'b0, 1'b1, 1'b0, 1'b1);
    runCycle(1'b1);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h5000_0044, 1'b1, 1'b1, 1'b1, 1'b1);
    runCycle(1'b1);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h5000_0044, 1'b1, 1'b1, 1'b1, 1'b0);
    runCycle(1'b1);

    $display("[TB] burst with dropped grant");
    applyStimulus(1'b1, 2'b10, 1'b1, 32'h3000_0000, 1'b1, 1'b1, 1'b1, 1'b0);
    runCycle(1'b1);
    applyStimulus(1'b1, 2'b11, 1'b1, 32'h3000_0004, 1'b1, 1'b1, 1'b1, 1'b0);
    runCycle(1'b1);
    applyStimulus(1'b1, 2'b11, 1'b1, 32'h3000_0008, 1'b0, 1'b1, 1'b1, 1'b0);
    runCycle(1'b1);
    applyStimulus(1'b1, 2'b11, 1'b1, 32'h3000_0008, 1'b0, 1'b1, 1'b1, 1'b0);
    runCycle(1'b1);
    applyStimulus(1'b1, 2'b11, 1'b1, 32'h3000_0008, 1'b1, 1'b1, 1'b1, 1'b0);
    runCycle(1'b1);
    applyStimulus(1'b1, 2'b11, 1'b1, 32'h3000_000C, 1'b1, 1'b1, 1'b1, 1'b0);
    runCycle(1'b1);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    runCycle(1'b1);

    $display("[TB] reset during pend");
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h6000_0100, 1'b0, 1'b1, 1'b1, 1'b0);
    runCycle(1'b1);
    runCycle(1'b1);
    HRESET = 1'b1;
    runCycle(1'b1);
    HRESET = 1'b0;
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    runCycle(1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      HRESET = ($urandom_range(0, 49) == 0);
      applyStimulus(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $urandom, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 5) == 0));
      runCycle(1'b1);
    end
    HRESET = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_mtx_input_stage.md
Name: ahb_mtx_input_stage

Overview:
- Per-master input stage of the L1 AHB bus matrix. It is the master-facing end of the path whose slave-facing end is the output-stage arbiter.
- Accepts the address phase from one AHB master and raises a request toward the output stages.
- If no output stage grants the port in the same cycle, it holds the address and control in a register and stalls the master's data phase.
- Passes the slave's data-phase response back to the master.

Parameters:
ADDR_WIDTH, 32, width of the address bus
HOLD_RESET_ADDR, 0, value loaded into the held address register at reset

Ports:
HCLK  input  1  AHB system clock
HRESET  input  1  synchronous active-high reset
HSELS  input  1  slave select from the master-side decoder
HADDRS  input  ADDR_WIDTH  master address
HTRANSS  input  2  master transfer type
HWRITES  input  1  master write
HSIZES  input  3  master size
HBURSTS  input  3  master burst
HPROTS  input  4  master protection
HMASTLOCKS  input  1  master lock
HREADYS  input  1  bus-level HREADY seen by the master
HREADYOUTS  output  1  ready returned to the master
HRESPS  output  1  response returned to the master (0 = OKAY, 1 = ERROR)
active_ip  input  1  output stage has selected this port for its address phase
HREADYM  input  1  HREADY on the granted output port
readyout_ip  input  1  slave HREADYOUT for this port's data phase
resp_ip  input  1  slave HRESP for this port's data phase
req_op  output  1  request to the arbiters (feeds req_portN)
sel_op, addr_op, trans_op, write_op, size_op, burst_op, prot_op, mastlock_op  output  1/ADDR_WIDTH/2/1/3/3/4/1  address/control presented to the output stages

Behaviour:
- Clock and reset: single clock HCLK. HRESET is synchronous, active-high, and sampled on the HCLK rising edge.
- Reset state:
  - state = IDLE.
  - Held registers cleared; held address = HOLD_RESET_ADDR.
  - HREADYOUTS = 1, HRESPS = 0, req_op = 0, trans_op = 2'b00.
- Valid transfer: new_tx = HSELS & HREADYS & HTRANSS[1] (NONSEQ or SEQ).
- IDLE/BUSY selected transfers (HSELS & HREADYS & ~HTRANSS[1]): zero-wait OKAY, never forwarded, no state change.
- States:
  - IDLE: HREADYOUTS = 1, HRESPS = 0.
    - new_tx & active_ip & HREADYM → DATA (pass-through, no hold).
    - new_tx otherwise → PEND; capture all address/control into the hold register on this edge.
  - PEND: HREADYOUTS = 0, HRESPS = 0; *_op driven from the hold register; req_op = 1.
    - active_ip & HREADYM → DATA.
    - Otherwise stay in PEND indefinitely; no timeout.
  - DATA: HREADYOUTS = readyout_ip, HRESPS = resp_ip.
    - readyout_ip = 1 ends the data phase and the master's HREADYS rises. In that cycle apply the IDLE rules to new_tx, i.e. back-to-back → DATA or PEND, else → IDLE.
    - readyout_ip = 0 → stay in DATA.
- Output mux:
  - *_op = hold register while in PEND.
  - Otherwise *_op = live master signals gated by HSELS & HREADYS; trans_op is forced to 2'b00 when ungated.
  - req_op = (state == PEND) | new_tx.
- ERROR: the two-cycle ERROR response is passed through unchanged, i.e. HRESPS = resp_ip with HREADYOUTS = 0 then 1. A new_tx arriving in the second ERROR cycle is handled as in DATA.
- Lock: mastlock_op follows the held/live HMASTLOCKS. The arbiter keeps the port while the lock is set; this block adds no lock logic.
- Reset mid-operation: PEND or DATA is abandoned and the reset state is loaded on the next edge; the hold contents are discarded.
- Latency:
  - Pass-through: zero added cycles.
  - Held: address phase issued N cycles late, where N = number of cycles in PEND; master data phase extended by N.

Test Plan:
1. Reset is asserted for 2 cycles, then released → HREADYOUTS = 1, HRESPS = 0, req_op = 0, trans_op = 0; state is IDLE.
2. NONSEQ write to 0x2000_0010 with active_ip = 1, HREADYM = 1, and readyout_ip = 1 on the next cycle → addr_op = 0x2000_0010 in the same cycle, no stall, HREADYOUTS = 1 throughout.
3. NONSEQ read to 0x4000_0000 with active_ip = 0 for 3 cycles, then 1 → PEND for 3 cycles, HREADYOUTS = 0, addr_op held at 0x4000_0000 while HADDRS is toggled; the read completes 3 cycles late.
4. Slave returns ERROR (resp_ip = 1, readyout_ip 0 then 1) → HRESPS = 1 for both cycles and HREADYOUTS = 0 then 1; an IDLE transfer follows and gets a zero-wait OKAY.
5. Back-to-back SEQ burst of 4 words; the grant is dropped on beat 3 for 2 cycles → beat 3 held in PEND, beats 1, 2 and 4 pass through, addresses stay in order.
6. Reset asserted during PEND → next cycle IDLE, req_op = 0, HREADYOUTS = 1, and the hold register is cleared to HOLD_RESET_ADDR.
